// File: rtl/calc_operand_sequencer.sv
// Sequences A, B and opcode from a shared switch bus into the ALU and captures its result for display.
// One press per debounced Enter edge; EXEC is a single cycle; no backpressure, the user paces every step.
module calc_operand_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter bit CHAIN_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] sw,
  input  logic       enter,
  input  logic       clear,
  input  logic [3:0] alu_result,
  input  logic       alu_overflow,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_opcode,
  output logic       alu_reset,
  output logic [3:0] disp_value,
  output logic       disp_ovf,
  output logic       done,
  output logic       op_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [3:0]             a_q, a_d, b_q, b_d, op_q, op_d, disp_q, disp_d;
  logic                   ovf_q, ovf_d, done_q, done_d, op_err_q, op_err_d;
  logic                   press;

  // Synchronizer and edge flop are deliberately untouched by clear so a held Enter cannot re-fire.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], enter};
    edge_d = sync_q[SYNC_STAGES-1];
    press  = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    disp_d   = disp_q;
    ovf_d    = ovf_q;
    op_err_d = op_err_q;
    done_d   = 1'b0;
    if (clear) begin
      state_d  = GET_A;
      a_d      = 4'h0;
      b_d      = 4'h0;
      op_d     = 4'h0;
      disp_d   = 4'h0;
      ovf_d    = 1'b0;
      op_err_d = 1'b0;
    end else begin
      case (state_q)
        GET_A: if (press) begin
          a_d     = sw;
          state_d = GET_B;
        end
        GET_B: if (press) begin
          b_d     = sw;
          state_d = GET_OP;
        end
        GET_OP: if (press) begin
          if (sw >= 4'hD) begin
            op_err_d = 1'b1;
          end else begin
            op_d     = sw;
            op_err_d = 1'b0;
            state_d  = EXEC;
          end
        end
        EXEC: begin
          // Modulo by zero is undefined in the ALU, so report it as an error here.
          if (op_q == 4'h9 && b_q == 4'h0) begin
            disp_d = 4'h0;
            ovf_d  = 1'b1;
          end else begin
            disp_d = alu_result;
            ovf_d  = alu_overflow;
          end
          done_d  = 1'b1;
          state_d = SHOW;
        end
        SHOW: if (press) begin
          if (CHAIN_EN) begin
            a_d     = disp_q;
            state_d = GET_B;
          end else begin
            state_d = GET_A;
          end
        end
        default: state_d = GET_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= GET_A;
      sync_q   <= '0;
      edge_q   <= 1'b0;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      op_q     <= 4'h0;
      disp_q   <= 4'h0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      edge_q   <= edge_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      op_err_q <= op_err_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign alu_reset  = (state_q != EXEC);
  assign disp_value = disp_q;
  assign disp_ovf   = ovf_q;
  assign done       = done_q;
  assign op_err     = op_err_q;
  assign state      = state_q;

endmodule

// File: doc/calc_operand_sequencer.md
Name: calc_operand_sequencer

Overview:
- Upstream control stage for the 4-bit calculator ALU.
- Collects A, B and opcode in sequence from a shared 4-bit switch bus. Each value is committed by an Enter button press.
- Drives the ALU operand, opcode and reset inputs, captures the ALU's combinational Result/Overflow into a held display register, and optionally chains the result into the next operation.
- Screens out opcodes the ALU leaves undefined, and modulo by zero.

Parameters:
- SYNC_STAGES, 2, number of flops in the enter synchronizer chain (≥2).
- CHAIN_EN, 1, 1 = an Enter press in SHOW loads the held result as A and goes to GET_B; 0 = the press returns to GET_A.

Ports:
- clk  in  1  system clock; all flops rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- sw  in  4  value switches, assumed quasi-static; sampled on a press.
- enter  in  1  raw Enter button level, asynchronous.
- clear  in  1  synchronous clear, active-high, already synchronous to clk.
- alu_result  in  4  ALU Result.
- alu_overflow  in  1  ALU Overflow.
- alu_a  out  4  operand A register, to the ALU A input.
- alu_b  out  4  operand B register, to the ALU B input.
- alu_opcode  out  4  opcode register, to the ALU Opcode input.
- alu_reset  out  1  active-high reset to the ALU.
- disp_value  out  4  captured result.
- disp_ovf  out  1  captured overflow/error.
- done  out  1  one-cycle pulse on result capture.
- op_err  out  1  rejected-opcode flag.
- state  out  3  FSM state code.

Behaviour:
- Reset (reset_n low, asynchronous) sets:
  - state = GET_A;
  - alu_a, alu_b, alu_opcode, disp_value = 0;
  - disp_ovf, done, op_err = 0;
  - all synchronizer and edge flops = 0.
- Enter synchronization and press detection:
  - enter passes through a SYNC_STAGES-deep flop chain, then one edge-detect flop.
  - press = last sync stage AND NOT edge flop.
  - A rising enter produces exactly one press. The FSM acts on the (SYNC_STAGES+1)th rising clk edge after enter is first sampled high.
  - Holding enter high produces no further presses. Re-arming requires enter to be sampled low.
- State codes: GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SHOW=4. Unused codes go to GET_A on the next edge.
- GET_A: on press, alu_a ← sw; go to GET_B.
- GET_B: on press, alu_b ← sw; go to GET_OP.
- GET_OP: on press:
  - if sw ≥ 4'hD: opcode is not latched, op_err ← 1, stay in GET_OP;
  - otherwise: alu_opcode ← sw, op_err ← 0, go to EXEC.
- EXEC: lasts exactly one cycle, no press is needed. On the exiting edge:
  - disp_value ← alu_result and disp_ovf ← alu_overflow;
  - exception: if alu_opcode = 4'h9 and alu_b = 0, capture disp_value ← 0 and disp_ovf ← 1 (modulo-by-zero error), ignoring the ALU outputs;
  - done = 1 for the first SHOW cycle only;
  - go to SHOW.
- SHOW: disp_value and disp_ovf are held. On press:
  - CHAIN_EN=1: alu_a ← disp_value (sw is ignored), go to GET_B;
  - CHAIN_EN=0: go to GET_A.
- alu_reset:
  - Combinational decode: 1 in every state except EXEC, 0 in EXEC.
  - In reset, alu_reset = 1.
  - The ALU therefore outputs 0 outside EXEC.
- Register persistence: disp_value and disp_ovf change only at EXEC exit, clear, or reset. alu_a, alu_b and alu_opcode hold their values until overwritten.
- clear (synchronous):
  - Effective from any state, with priority over a simultaneous press.
  - Next state = GET_A.
  - alu_a, alu_b, alu_opcode, disp_value = 0; disp_ovf, op_err, done = 0.
  - The synchronizer is not cleared, so a held enter does not re-trigger.
- Reset asserted mid-sequence (any state, including EXEC) abandons the operation immediately and does no capture.
- Widths: all data paths are 4 bits, with no extension and no arithmetic inside this block.

Test Plan:
- Reset, then release -> state=0, alu_reset=1, disp_value=0, disp_ovf=0, done=0, op_err=0; holding enter high for 20 cycles advances exactly one state.
- Enter the sequence sw=5, sw=3, sw=3 (add) -> state EXEC for 1 cycle with alu_a=5, alu_b=3, alu_opcode=3, alu_reset=0; then disp_value=8, disp_ovf=0, done pulses once, state=4.
- Enter A=9, B=9, op=3 -> disp_value=2, disp_ovf=1 (from the ALU); then sw=4'hE in GET_OP on the next run -> state stays 2, op_err=1; then sw=2 -> op_err=0, proceeds to EXEC.
- Enter A=7, B=0, op=9 -> disp_value=0, disp_ovf=1 regardless of alu_result (drive X on alu_result).
- CHAIN_EN=1: after 5+3=8, press in SHOW with sw=F -> alu_a=8, state=1; then B=2, op=4 -> disp_value=0, disp_ovf=1.
- In GET_OP, assert clear together with a press -> state=0 and all registers 0; separately, pulse reset_n low during EXEC -> no done pulse, disp_value stays 0.
